// File: rtl/mlp_core.sv
// Two-layer MLP inference engine: one shared 8x8 MAC sweeps the hidden layer, then
// the output layer, and reports the argmax of the activated output neurons.
module mlp_core #(
    parameter int N_IN      = 784,
    parameter int N_HID     = 32,
    parameter int N_OUT     = 10,
    parameter int IN_BINARY = 1,
    localparam int AI       = $clog2(N_IN),
    localparam int AH       = $clog2(N_HID),
    localparam int AO       = $clog2(N_OUT),
    localparam int ACC_W    = 16 + AI + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [AO-1:0]  digit,
    output logic [7:0]     max_val,
    output logic [AI-1:0]  in_addr,
    input  logic [7:0]     in_q,
    output logic [AH+AI-1:0] wh_addr,
    input  logic [7:0]     wh_q,
    output logic [AO+AH-1:0] wo_addr,
    input  logic [7:0]     wo_q,
    output logic [10:0]    lut_addr,
    input  logic [7:0]     lut_q
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        HID_MAC = 4'd1,
        HID_DR1 = 4'd2,
        HID_DR2 = 4'd3,
        HID_WR  = 4'd4,
        OUT_MAC = 4'd5,
        OUT_DR1 = 4'd6,
        OUT_DR2 = 4'd7,
        OUT_WR  = 4'd8,
        DONE    = 4'd9
    } state_t;

    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(1023);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-1024);

    state_t                   state_r, state_nxt;
    logic                     busy_r, done_r;
    logic [AI-1:0]            in_cnt_r;
    logic [AH-1:0]            hid_cnt_r;
    logic [AO-1:0]            out_cnt_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_nxt_s;
    logic signed [ACC_W-1:0]  sh_s;
    logic [10:0]              lut_idx_s;
    logic [10:0]              lut_addr_r;
    logic                     prod_en_r;
    logic                     phase_out_r;
    logic [7:0]               hram [N_HID];
    logic [7:0]               hram_q_r;
    logic signed [7:0]        in_op_s, op_a_s, op_b_s;
    logic signed [15:0]       prod_s;
    logic [7:0]               best_val_r, max_val_r;
    logic [AO-1:0]            best_idx_r, digit_r;
    logic                     in_last_s, hid_last_s, out_last_s;

    assign in_last_s  = (in_cnt_r == AI'(N_IN - 1));
    assign hid_last_s = (hid_cnt_r == AH'(N_HID - 1));
    assign out_last_s = (out_cnt_r == AO'(N_OUT - 1));

    assign busy     = busy_r;
    assign done     = done_r;
    assign digit    = digit_r;
    assign max_val  = max_val_r;
    assign in_addr  = in_cnt_r;
    assign wh_addr  = {hid_cnt_r, in_cnt_r};
    assign wo_addr  = {out_cnt_r, hid_cnt_r};
    assign lut_addr = lut_addr_r;

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state_r;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (start) state_nxt = HID_MAC; else state_nxt = IDLE;
                HID_MAC: if (in_last_s) state_nxt = HID_DR1; else state_nxt = HID_MAC;
                HID_DR1: state_nxt = HID_DR2;
                HID_DR2: state_nxt = HID_WR;
                HID_WR:  if (hid_last_s) state_nxt = OUT_MAC; else state_nxt = HID_MAC;
                OUT_MAC: if (hid_last_s) state_nxt = OUT_DR1; else state_nxt = OUT_MAC;
                OUT_DR1: state_nxt = OUT_DR2;
                OUT_DR2: state_nxt = OUT_WR;
                OUT_WR:  if (out_last_s) state_nxt = DONE; else state_nxt = OUT_MAC;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register with busy/done decoded one cycle early so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            busy_r  <= (state_nxt != IDLE);
            done_r  <= (state_nxt == DONE);
        end
    end

    // Input operand: binary pixels map to full-scale positive or zero.
    always_comb begin
        if (IN_BINARY != 0) begin
            if (in_q[0]) in_op_s = 8'sd127; else in_op_s = 8'sd0;
        end else begin
            in_op_s = in_q;
        end
    end

    // MAC operand select, using the phase of the cycle that issued the address.
    always_comb begin
        if (phase_out_r) begin
            op_a_s = hram_q_r;
            op_b_s = wo_q;
        end else begin
            op_a_s = in_op_s;
            op_b_s = wh_q;
        end
    end

    assign prod_s    = 16'(op_a_s) * 16'(op_b_s);
    assign acc_nxt_s = acc_r + {{(ACC_W-16){prod_s[15]}}, prod_s};
    assign sh_s      = acc_nxt_s >>> 7;

    // Saturate the scaled sum; adding 1024 to an 11-bit two's complement value flips its MSB.
    always_comb begin
        if (sh_s > S_MAX) begin
            lut_idx_s = 11'd2047;
        end else if (sh_s < S_MIN) begin
            lut_idx_s = 11'd0;
        end else begin
            lut_idx_s = sh_s[10:0] ^ 11'h400;
        end
    end

    // Term and neuron counters; each clears on its terminal count instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_r  <= {AI{1'b0}};
            hid_cnt_r <= {AH{1'b0}};
            out_cnt_r <= {AO{1'b0}};
        end else if (abort) begin
            in_cnt_r  <= {AI{1'b0}};
            hid_cnt_r <= {AH{1'b0}};
            out_cnt_r <= {AO{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        in_cnt_r  <= {AI{1'b0}};
                        hid_cnt_r <= {AH{1'b0}};
                        out_cnt_r <= {AO{1'b0}};
                    end
                end
                HID_MAC: begin
                    if (in_last_s) in_cnt_r <= {AI{1'b0}};
                    else           in_cnt_r <= in_cnt_r + 1'b1;
                end
                HID_WR, OUT_MAC: begin
                    if (hid_last_s) hid_cnt_r <= {AH{1'b0}};
                    else            hid_cnt_r <= hid_cnt_r + 1'b1;
                end
                OUT_WR: begin
                    if (out_last_s) out_cnt_r <= {AO{1'b0}};
                    else            out_cnt_r <= out_cnt_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Accumulator: one product per cycle trailing the address by the memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= {ACC_W{1'b0}};
            lut_addr_r  <= 11'd0;
            prod_en_r   <= 1'b0;
            phase_out_r <= 1'b0;
        end else if (abort) begin
            acc_r       <= {ACC_W{1'b0}};
            prod_en_r   <= 1'b0;
            phase_out_r <= 1'b0;
        end else begin
            prod_en_r   <= (state_r == HID_MAC) || (state_r == OUT_MAC);
            phase_out_r <= (state_r == OUT_MAC);
            case (state_r)
                IDLE: if (start) acc_r <= {ACC_W{1'b0}};
                HID_WR, OUT_WR: acc_r <= {ACC_W{1'b0}};
                HID_DR1, OUT_DR1: begin
                    acc_r      <= acc_nxt_s;
                    lut_addr_r <= lut_idx_s;
                end
                default: if (prod_en_r) acc_r <= acc_nxt_s;
            endcase
        end
    end

    // Hidden activation RAM, synchronous read.
    always_ff @(posedge clk) begin
        if (state_r == HID_WR && !abort) hram[hid_cnt_r] <= lut_q;
        hram_q_r <= hram[hid_cnt_r];
    end

    // Running argmax; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_val_r <= 8'd0;
            best_idx_r <= {AO{1'b0}};
            digit_r    <= {AO{1'b0}};
            max_val_r  <= 8'd0;
        end else if (!abort) begin
            case (state_r)
                OUT_WR: begin
                    if (out_cnt_r == {AO{1'b0}} || lut_q > best_val_r) begin
                        best_val_r <= lut_q;
                        best_idx_r <= out_cnt_r;
                    end
                end
                DONE: begin
                    digit_r   <= best_idx_r;
                    max_val_r <= best_val_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_core.sv
// Directed bench for mlp_core: three instances (tiny signed, default binary, saturation).
module tb_mlp_core;

    logic clk, rst_n;
    int   n_vec, n_miss;

    // Instance A: N_IN=4, N_HID=2, N_OUT=3, signed samples
    logic a_start, a_abort, a_busy, a_done;
    logic [1:0] a_digit, a_in_addr;
    logic [7:0] a_max, a_in_q, a_wh_q, a_wo_q, a_lut_q;
    logic [2:0] a_wh_addr, a_wo_addr;
    logic [10:0] a_lut_addr;
    logic [7:0] a_in_val, a_wh_val;
    logic [7:0] a_wo [4];
    logic       a_tie;

    // Instance B: default parameters, binary pixels
    logic b_start, b_busy, b_done;
    logic [3:0] b_digit;
    logic [9:0] b_in_addr;
    logic [14:0] b_wh_addr;
    logic [8:0] b_wo_addr;
    logic [7:0] b_max, b_in_q, b_wh_q, b_wo_q, b_lut_q;
    logic [10:0] b_lut_addr;

    // Instance C: N_IN=64, N_HID=2, N_OUT=2, binary pixels, drives saturation
    logic c_start, c_busy, c_done;
    logic [0:0] c_digit;
    logic [5:0] c_in_addr;
    logic [6:0] c_wh_addr;
    logic [1:0] c_wo_addr;
    logic [7:0] c_max, c_in_q, c_wh_q, c_wo_q, c_lut_q;
    logic [10:0] c_lut_addr;
    logic [7:0] c_in_val, c_wh_val;

    mlp_core #(.N_IN(4), .N_HID(2), .N_OUT(3), .IN_BINARY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done), .digit(a_digit), .max_val(a_max),
        .in_addr(a_in_addr), .in_q(a_in_q), .wh_addr(a_wh_addr), .wh_q(a_wh_q),
        .wo_addr(a_wo_addr), .wo_q(a_wo_q), .lut_addr(a_lut_addr), .lut_q(a_lut_q));

    mlp_core u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0),
        .busy(b_busy), .done(b_done), .digit(b_digit), .max_val(b_max),
        .in_addr(b_in_addr), .in_q(b_in_q), .wh_addr(b_wh_addr), .wh_q(b_wh_q),
        .wo_addr(b_wo_addr), .wo_q(b_wo_q), .lut_addr(b_lut_addr), .lut_q(b_lut_q));

    mlp_core #(.N_IN(64), .N_HID(2), .N_OUT(2), .IN_BINARY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(1'b0),
        .busy(c_busy), .done(c_done), .digit(c_digit), .max_val(c_max),
        .in_addr(c_in_addr), .in_q(c_in_q), .wh_addr(c_wh_addr), .wh_q(c_wh_q),
        .wo_addr(c_wo_addr), .wo_q(c_wo_q), .lut_addr(c_lut_addr), .lut_q(c_lut_q));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models, all one-cycle synchronous read
    always @(posedge clk) begin
        a_in_q  <= a_in_val;
        a_wh_q  <= a_wh_val;
        a_wo_q  <= a_wo[a_wo_addr[2:1]];
        a_lut_q <= a_tie ? 8'h40 : a_lut_addr[7:0];
        b_in_q  <= 8'h00;
        b_wh_q  <= 8'h55;
        b_wo_q  <= (b_wo_addr[8:5] == 4'd3) ? 8'd20 : {4'd0, b_wo_addr[8:5]};
        b_lut_q <= b_lut_addr[7:0] + {5'd0, b_lut_addr[10:8]};
        c_in_q  <= c_in_val;
        c_wh_q  <= c_wh_val;
        c_wo_q  <= 8'h00;
        c_lut_q <= 8'h00;
    end

    int sel;
    logic s_done, s_busy;
    logic [10:0] s_lut;
    always_comb begin
        case (sel)
            1:       begin s_done = b_done; s_busy = b_busy; s_lut = b_lut_addr; end
            2:       begin s_done = c_done; s_busy = c_busy; s_lut = c_lut_addr; end
            default: begin s_done = a_done; s_busy = a_busy; s_lut = a_lut_addr; end
        endcase
    end

    int r_done_at, r_done_cnt, r_busy_after, r_p1, r_p2;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            1:       b_start = v;
            2:       c_start = v;
            default: a_start = v;
        endcase
    endtask

    // Cycle n is the cycle after the n-th clock edge following the start-sampling cycle.
    task automatic run(input int which, input int abort_at, input int hold_until,
                       input int p1, input int p2, input int budget);
        r_done_at = -1; r_done_cnt = 0; r_busy_after = -1; r_p1 = -1; r_p2 = -1;
        sel = which;
        @(negedge clk);
        set_start(which, 1'b1);
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            set_start(which, n < hold_until);
            a_abort = (n == abort_at);
            if (s_done) begin
                r_done_cnt++;
                if (r_done_at < 0) r_done_at = n;
            end
            if (n == abort_at + 1) r_busy_after = int'(s_busy);
            if (n == p1) r_p1 = int'(s_lut);
            if (n == p2) r_p2 = int'(s_lut);
        end
        a_abort = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0; sel = 0;
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; a_abort = 1'b0;
        a_in_val = 8'd64; a_wh_val = 8'd1; a_tie = 1'b0;
        a_wo[0] = 8'd1; a_wo[1] = 8'd1; a_wo[2] = 8'd1; a_wo[3] = 8'd0;
        c_in_val = 8'h01; c_wh_val = 8'd127;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_digit", a_digit, 0);
        check_val("rst_max", a_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 4 inputs of 64, unit weights: acc=256 -> lut_addr 1026 per hidden neuron
        run(0, -1, 0, 6, 13, 40);
        check_val("a_done_at", r_done_at, 30);
        check_val("a_done_cnt", r_done_cnt, 1);
        check_val("a_lut_h0", r_p1, 1026);
        check_val("a_lut_h1", r_p2, 1026);
        check_val("a_digit0", a_digit, 0);
        check_val("a_max0", a_max, 0);

        // Output sums 256, 508, -512 -> LUT 2, 3, 0xFC; start held through the run
        a_wo[0] = 8'd64; a_wo[1] = 8'd127; a_wo[2] = 8'h80;
        run(0, -1, 29, 0, 0, 40);
        check_val("argmax_done_at", r_done_at, 30);
        check_val("argmax_done_cnt", r_done_cnt, 1);
        check_val("argmax_digit", a_digit, 2);
        check_val("argmax_max", a_max, 252);

        // Abort in the first OUT_MAC cycle
        a_tie = 1'b1;
        run(0, 15, 0, 0, 0, 40);
        check_val("abort_busy", r_busy_after, 0);
        check_val("abort_done_cnt", r_done_cnt, 0);
        check_val("abort_digit", a_digit, 2);
        check_val("abort_max", a_max, 252);

        // All output LUT values equal: lowest index wins
        run(0, -1, 0, 0, 0, 40);
        check_val("tie_done_at", r_done_at, 30);
        check_val("tie_digit", a_digit, 0);
        check_val("tie_max", a_max, 8'h40);

        a_tie = 1'b0;
        run(0, -1, 0, 0, 0, 40);
        check_val("rerun_digit", a_digit, 2);

        // Reset mid-HID_MAC with start held high
        sel = 0;
        @(negedge clk);
        a_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mrst_busy", a_busy, 0);
        check_val("mrst_done", a_done, 0);
        check_val("mrst_digit", a_digit, 0);
        check_val("mrst_max", a_max, 0);
        @(negedge clk);
        rst_n = 1'b1; a_start = 1'b0;
        r_done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (a_done) r_done_cnt++;
        end
        check_val("mrst_no_done", r_done_cnt, 0);
        check_val("mrst_idle", a_busy, 0);

        // Saturation with 64 binary pixels set
        c_in_val = 8'h01; c_wh_val = 8'd127;
        run(2, -1, 0, 66, 133, 150);
        check_val("sat_hi_h0", r_p1, 2047);
        check_val("sat_hi_h1", r_p2, 2047);
        check_val("c_done_at", r_done_at, 145);
        c_wh_val = 8'h80;
        run(2, -1, 0, 66, 133, 150);
        check_val("sat_lo_h0", r_p1, 0);
        check_val("sat_lo_h1", r_p2, 0);
        // Binary mode reads bit 0 only
        c_in_val = 8'hFE; c_wh_val = 8'd127;
        run(2, -1, 0, 66, 0, 150);
        check_val("bin_bit0", r_p1, 1024);

        // Default parameters, all-zero image: hidden acts 4, output sums 128*w -> LUT w+4
        run(1, -1, 0, 0, 0, 25540);
        check_val("dflt_done_at", r_done_at, 25535);
        check_val("dflt_done_cnt", r_done_cnt, 1);
        check_val("dflt_digit", b_digit, 3);
        check_val("dflt_max", b_max, 24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mlp_core.md
MLP_CORE -- requirements
Module: mlp_core

Interface
REQ-001 Parameters SHALL be: N_IN, default 784, number of inputs per hidden neuron; N_HID, default 32, number of hidden neurons; N_OUT, default 10, number of output neurons (2..16); IN_BINARY, default 1, input mode (1 = 1-bit pixel, 0 = 8-bit signed sample).
REQ-002 Derived widths SHALL be: AI = clog2(N_IN), AH = clog2(N_HID), AO = clog2(N_OUT), ACC_W = 16 + AI + 1.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk.
- start  in  1  run request, sampled in IDLE only.
- abort  in  1  synchronous cancel.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.
- digit  out  AO  argmax index of the last completed run.
- max_val  out  8  LUT value at digit.
- in_addr  out  AI  input memory address.
- in_q  in  8  input data; bit 0 only when IN_BINARY=1.
- wh_addr  out  AH+AI  hidden-weight ROM address {hid, in}.
- wh_q  in  8  signed hidden weight.
- wo_addr  out  AO+AH  output-weight ROM address {out, hid}.
- wo_q  in  8  signed output weight.
- lut_addr  out  11  activation LUT address.
- lut_q  in  8  activation result.
REQ-004 All external memories SHALL be synchronous-read with 1-cycle latency: data is valid the cycle after the address.

Function
REQ-005 Hidden activations SHALL be held in an internal N_HID x 8 RAM with 1-cycle read latency, written with lut_q.
REQ-006 The input operand SHALL be 127 when IN_BINARY=1 and in_q[0]=1, 0 when IN_BINARY=1 and in_q[0]=0, and in_q taken as signed when IN_BINARY=0.
REQ-007 The MAC SHALL accumulate signed 8x8 products into an ACC_W-bit signed register, cleared synchronously.
REQ-008 The LUT index SHALL be s = acc>>>7, saturated to [-1024, 1023], with lut_addr = s + 1024 (11-bit, unsigned).
REQ-009 The FSM states SHALL be IDLE, HID_MAC, HID_DR1, HID_DR2, HID_WR, OUT_MAC, OUT_DR1, OUT_DR2, OUT_WR, DONE.
REQ-010 IDLE with start=1 SHALL clear acc and all counters and go to HID_MAC.
REQ-011 HID_MAC SHALL issue in_addr/wh_addr 0..N_IN-1, one per cycle, then go to HID_DR1.
REQ-012 HID_DR1 SHALL accumulate the last product, and HID_DR2 SHALL present lut_addr.
REQ-013 HID_WR SHALL write lut_q into hidden RAM at the current hid index and clear acc.
REQ-014 From HID_WR the FSM SHALL go to HID_MAC with hid+1 if hid < N_HID-1; otherwise it SHALL clear hid and go to OUT_MAC.
REQ-015 OUT_MAC, OUT_DR1, OUT_DR2 and OUT_WR SHALL mirror REQ-011 to REQ-013, using hidden-RAM/wo operands over N_HID terms.
REQ-016 In OUT_WR with out=0, the FSM SHALL load best_val=lut_q and best_idx=0 unconditionally.
REQ-017 In OUT_WR with out>0, the FSM SHALL update best only if lut_q > best_val (unsigned, strict), so ties keep the lowest index.
REQ-018 From OUT_WR the FSM SHALL go to OUT_MAC with out+1 if out < N_OUT-1; otherwise it SHALL go to DONE.
REQ-019 DONE SHALL assert done for 1 cycle, copy best_idx/best_val to digit/max_val, and return to IDLE.
REQ-020 done SHALL assert exactly L = 1 + N_HID*(N_IN+3) + N_OUT*(N_HID+3) cycles after the cycle in which start was sampled (25535 for the default parameters).
REQ-021 start SHALL be ignored while busy.
REQ-022 abort SHALL take priority over every transition: the FSM SHALL go to IDLE next cycle, with no done pulse and digit/max_val unchanged.
REQ-023 Counters SHALL never wrap; each terminal count SHALL be detected by equality with N-1.

Reset
REQ-024 While rst_n=0, the FSM SHALL be in IDLE, and busy, done, digit, max_val, all counters, acc, best_val and best_idx SHALL be 0.
REQ-025 Reset asserted mid-run SHALL abandon the run with no done pulse; hidden RAM contents are don't-care.

Verification
REQ-026 Defaults, all-zero input image -> done at cycle 25535, digit = argmax over the LUT of the output-bias-free sums, matching the golden model.
REQ-027 N_IN=4, N_HID=2, N_OUT=3, IN_BINARY=0, all weights 1, in_q=64 -> acc=256, lut_addr=1026 for every hidden neuron; done at cycle 30.
REQ-028 Saturation: weights 127, in_q=127 -> lut_addr=2047; weights -128, in_q=127 -> lut_addr=0.
REQ-029 Tie: all output LUT values equal to 0x40 -> digit=0, max_val=0x40.
REQ-030 abort pulsed in OUT_MAC -> IDLE next cycle, no done, digit holds its prior value; a new start then completes normally with done at L.
REQ-031 start held high during a run and rst_n pulsed mid-HID_MAC -> outputs all 0 and no done pulse.
